btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Upstream input stage between the raw BASYS3 push-buttons and the Tetris game logic (move/rotate/change/pause commands).
- Synchronises, debounces and edge-detects each button.
- Delivers a one-cycle command pulse per press, with auto-repeat on move buttons, plus a toggled pause level.
- Runs on the 25 MHz pixel clock `clk`.

Parameters:
- NUM_BTN, 5, number of button channels; index 0 = left, 1 = right, 2 = fall, 3 = rotate, 4 = pause.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz).
- REPEAT_DELAY, 7500000, held cycles from the first pulse to the first repeat pulse (300 ms).
- REPEAT_PERIOD, 2500000, cycles between subsequent repeat pulses (100 ms).
- REPEAT_MASK, 5'b00111, per-channel auto-repeat enable; the bit at PAUSE_IDX is ignored and forced 0.
- PAUSE_IDX, 4, channel whose press toggles pause_state.

Ports:
- clk  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-low reset.
- btn_raw  in  NUM_BTN  raw button levels, active-high, asynchronous to clk.
- btn_level  out  NUM_BTN  debounced button level.
- btn_pulse  out  NUM_BTN  one-cycle command pulse (press and repeats).
- pause_state  out  1  pause level, toggled on each accepted pause press.

Behaviour:
- Reset (reset=0, asynchronous): btn_level, btn_pulse, pause_state, synchroniser flops and all counters go to 0. Normal operation resumes on the first clk edge after reset returns to 1.
- Synchroniser: two flops per channel; s = second-stage output.
- Debounce, per channel:
  - Counter dcnt, width $clog2(DEBOUNCE_CYCLES).
  - s == btn_level: dcnt <= 0.
  - s != btn_level and dcnt == DEBOUNCE_CYCLES-1: btn_level <= s, dcnt <= 0.
  - Otherwise: dcnt++.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_level.
- Latency: a clean rise of btn_raw sampled at edge k gives btn_level=1 and btn_pulse=1 at edge k+DEBOUNCE_CYCLES+1. Release has the same latency and produces no pulse.
- Per-channel FSM:
  - IDLE → PRESS on btn_level rising; btn_pulse=1 for exactly that cycle.
  - PRESS (rcnt counting, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD))): at rcnt == REPEAT_DELAY-1 emit pulse, rcnt <= 0, → REPEAT. Only for repeat-enabled channels; non-repeat channels stay in PRESS with no pulses.
  - REPEAT: at rcnt == REPEAT_PERIOD-1 emit pulse, rcnt <= 0.
  - Any state → IDLE in the cycle btn_level falls; rcnt <= 0; no pulse that cycle.
- Pause: pause_state toggles in the same cycle btn_pulse[PAUSE_IDX] is high. Pause never repeats.
- Channels are fully independent; simultaneous presses give simultaneous pulses.
- All outputs are registered; no combinational path from btn_raw.
- Reset mid-press: the channel returns to IDLE with no pulse. A button still held after reset is re-debounced and produces one fresh press pulse.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: PRESS/REPEAT auto-repeat behaviour as above, governed by REPEAT_MASK.
- Undefined: repeat counters and the REPEAT state are not built. The FSM is IDLE/PRESS only, and each press yields exactly one pulse regardless of REPEAT_MASK.

Decomposition:
- Shared package btn_pkg:
  - FSM state enum (IDLE, PRESS, REPEAT).
  - Channel index constants BTN_LEFT, BTN_RIGHT, BTN_FALL, BTN_ROTATE, BTN_PAUSE.
  - Counter-width function (clog2 wrapper).
- One natural sub-module: btn_channel (synchroniser, debounce, FSM for one button), instantiated NUM_BTN times via generate.
- pause_state toggle logic lives in the top level.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, macro defined.
1. btn_raw[0] rises before edge 0 and is held → btn_level[0]=1 and btn_pulse[0] high at edge 5 only; repeat pulses at edges 15, 18, 21; release → pulses stop, btn_level[0]=0 five edges after the raw fall.
2. btn_raw[3] (rotate, non-repeat) held 40 cycles → exactly one pulse, at edge 5.
3. btn_raw[1] glitch high for 3 cycles, then low → btn_level[1] and btn_pulse[1] stay 0 throughout.
4. Two clean pause presses → pause_state goes 0→1 at the first pulse and 1→0 at the second; no repeat even with REPEAT_MASK bit 4 set.
5. reset asserted low while channel 0 is in REPEAT with btn_raw held → all outputs 0 immediately (asynchronous); after release, one new pulse at edge 5 relative to the first post-reset edge, then repeats resume from REPEAT_DELAY.
6. Macro undefined, channel 0 held 40 cycles → single pulse at edge 5; channels 0 and 1 pressed in the same cycle → simultaneous pulses.

Source files
------------

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : btn_pkg
// Brief   : Shared constants, FSM encodings and counter-width helper for the
//           button conditioner.
// Revision: 1.0
// ============================================================================
package btn_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_PRESS  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   localparam int BTN_LEFT   = 0;
   localparam int BTN_RIGHT  = 1;
   localparam int BTN_FALL   = 2;
   localparam int BTN_ROTATE = 3;
   localparam int BTN_PAUSE  = 4;

   // Never returns 0 so a counter for a 1-cycle limit still has a legal width.
   function automatic int cnt_width(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
// Module  : btn_channel
// Brief   : One button: 2-flop synchroniser, debounce, press/repeat FSM.
//           Auto-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
// Revision: 1.0
// ============================================================================
module btn_channel
   import btn_pkg::*;
#(
`ifdef BTN_AUTO_REPEAT_EN
   parameter int   REPEAT_DELAY    = 7500000,
   parameter int   REPEAT_PERIOD   = 2500000,
   parameter logic REPEAT_EN       = 1'b0,
`endif
   parameter int   DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic pulse,
   output logic pulse_next
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync_s;
   logic [DW-1:0] dcnt;
   logic [1:0]    state;
   logic [1:0]    state_next;
   logic          accept;
   logic          rise;
   logic          fall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= 1'b0;
         sync_s <= 1'b0;
      end else begin
         sync1  <= raw;
         sync_s <= sync1;
      end
   end

   assign accept = (sync_s != level) && (dcnt == DMAX);
   assign rise   = accept &  sync_s;
   assign fall   = accept & ~sync_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dcnt  <= '0;
         level <= 1'b0;
      end else if (sync_s == level) begin
         dcnt <= '0;
      end else if (accept) begin
         level <= sync_s;
         dcnt  <= '0;
      end else begin
         dcnt <= dcnt + 1'b1;
      end
   end

`ifdef BTN_AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = cnt_width(RMAX);
   localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rcnt;
   logic [RW-1:0] rcnt_next;

   always_comb begin
      state_next = state;
      rcnt_next  = rcnt;
      pulse_next = 1'b0;
      // A debounced release wins over any repeat that would fire this cycle.
      if (fall) begin
         state_next = ST_IDLE;
         rcnt_next  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rise) begin
                  state_next = ST_PRESS;
                  rcnt_next  = '0;
                  pulse_next = 1'b1;
               end
            end
            ST_PRESS: begin
               if (REPEAT_EN) begin
                  if (rcnt == DELAY_MAX) begin
                     state_next = ST_REPEAT;
                     rcnt_next  = '0;
                     pulse_next = 1'b1;
                  end else begin
                     rcnt_next = rcnt + 1'b1;
                  end
               end
            end
            ST_REPEAT: begin
               if (rcnt == PERIOD_MAX) begin
                  rcnt_next  = '0;
                  pulse_next = 1'b1;
               end else begin
                  rcnt_next = rcnt + 1'b1;
               end
            end
            default: begin
               state_next = ST_IDLE;
               rcnt_next  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcnt <= '0;
      end else begin
         rcnt <= rcnt_next;
      end
   end
`else
   always_comb begin
      state_next = state;
      pulse_next = 1'b0;
      if (fall) begin
         state_next = ST_IDLE;
      end else if ((state == ST_IDLE) && rise) begin
         state_next = ST_PRESS;
         pulse_next = 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         pulse <= 1'b0;
      end else begin
         state <= state_next;
         pulse <= pulse_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : btn_conditioner
// Brief   : Conditions NUM_BTN raw push-buttons into debounced levels, command
//           pulses and a pause toggle. Auto-repeat enabled by the
//           BTN_AUTO_REPEAT_EN macro.
// Revision: 1.0
// ============================================================================
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int                 NUM_BTN         = 5,
   parameter int                 DEBOUNCE_CYCLES = 250000,
   parameter int                 REPEAT_DELAY    = 7500000,
   parameter int                 REPEAT_PERIOD   = 2500000,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b00111,
   parameter int                 PAUSE_IDX       = BTN_PAUSE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse,
   output logic               pause_state
);

   logic [NUM_BTN-1:0] pulse_next;

   generate
      for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
`ifdef BTN_AUTO_REPEAT_EN
         // Pause must never auto-repeat, whatever the mask says.
         localparam logic REP_EN = REPEAT_MASK[i] && (i != PAUSE_IDX);

         btn_channel #(
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REP_EN),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .raw        (btn_raw[i]),
            .level      (btn_level[i]),
            .pulse      (btn_pulse[i]),
            .pulse_next (pulse_next[i])
         );
`else
         btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .raw        (btn_raw[i]),
            .level      (btn_level[i]),
            .pulse      (btn_pulse[i]),
            .pulse_next (pulse_next[i])
         );
`endif
      end
   endgenerate

   // Toggle on the pre-register pulse so pause_state changes with btn_pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pause_state <= 1'b0;
      end else if (pulse_next[PAUSE_IDX]) begin
         pause_state <= ~pause_state;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_btn_conditioner
// Brief   : Directed scoreboard bench for btn_conditioner (repeat expectations
//           follow BTN_AUTO_REPEAT_EN).
// Revision: 1.0
// ============================================================================
module tb_btn_conditioner;

   localparam int         NB    = 5;
   localparam int         DEB   = 4;
   localparam int         RDLY  = 10;
   localparam int         RPER  = 3;
   localparam logic [4:0] RMASK = 5'b10111;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [NB-1:0] btn_raw = '0;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_pulse;
   logic          pause_state;

   btn_conditioner #(
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RDLY),
      .REPEAT_PERIOD   (RPER),
      .REPEAT_MASK     (RMASK),
      .PAUSE_IDX       (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_pulse   (btn_pulse),
      .pause_state (pause_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [4:0] mask;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;
   logic       exp_pause = 1'b0;
   logic [4:0] rmask_v = RMASK;

   function automatic bit rep_en(input int ch);
`ifdef BTN_AUTO_REPEAT_EN
      return rmask_v[ch] && (ch != 4);
`else
      return 1'b0;
`endif
   endfunction

   task automatic push(input int c, input int ch);
      logic [4:0] m;
      m     = '0;
      m[ch] = 1'b1;
      sb.push_back('{c, m});
   endtask

   // Expected pulses for a clean press of 'hold' raw cycles sampled first at edge k.
   task automatic schedule(input int ch, input int k, input int hold);
      int p;
      int fall;
      p    = k + DEB + 1;
      fall = k + hold + DEB + 1;
      push(p, ch);
      if (rep_en(ch)) begin
         for (int t = p + RDLY; t < fall; t += RPER) push(t, ch);
      end
   endtask

   task automatic start(input logic [4:0] m, input int hold, output int k);
      k       = cyc + 1;
      btn_raw = btn_raw | m;
      for (int ch = 0; ch < NB; ch++) if (m[ch]) schedule(ch, k, hold);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic release_btn(input logic [4:0] m, input int k, input int hold);
      wait_cyc(k + hold - 1);
      btn_raw = btn_raw & ~m;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin : mon
      logic [4:0] e;
      if (mon_en) begin
         e = '0;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
               e = e | sb[i].mask;
               sb.delete(i);
            end
         end
         if (e[4]) exp_pause = ~exp_pause;
         checks++;
         assert (btn_pulse === e) else begin
            errors++;
            $error("FAIL pulse@%0d: observed %b expected %b", cyc, btn_pulse, e);
         end
         checks++;
         assert (pause_state === exp_pause) else begin
            errors++;
            $error("FAIL pause@%0d: observed %b expected %b", cyc, pause_state, exp_pause);
         end
      end
   end

   initial begin
      #2000000;
      $error("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      repeat (3) @(negedge clk);
      check("rst_level", 32'(btn_level), 32'h0);
      check("rst_pulse", 32'(btn_pulse), 32'h0);
      check("rst_pause", 32'(pause_state), 32'h0);
      @(negedge clk);
      reset  = 1'b1;
      mon_en = 1'b1;
      repeat (4) @(negedge clk);

      // Left held: first pulse, repeats, release latency
      start(5'b00001, 23, k);
      wait_cyc(k + DEB);
      check("s1_level_pre", 32'(btn_level[0]), 32'h0);
      wait_cyc(k + DEB + 1);
      check("s1_level_on", 32'(btn_level[0]), 32'h1);
      release_btn(5'b00001, k, 23);
      wait_cyc(k + 23 + DEB);
      check("s1_level_hold", 32'(btn_level[0]), 32'h1);
      wait_cyc(k + 23 + DEB + 1);
      check("s1_level_off", 32'(btn_level[0]), 32'h0);
      repeat (20) @(negedge clk);

      // Rotate (non-repeat) held 40 cycles
      start(5'b01000, 40, k);
      release_btn(5'b01000, k, 40);
      repeat (15) @(negedge clk);

      // Short glitch on right
      btn_raw[1] = 1'b1;
      repeat (3) @(negedge clk);
      btn_raw[1] = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("s3_glitch_level", 32'(btn_level[1]), 32'h0);
      end

      // Two pause presses, mask bit 4 set but never repeats
      start(5'b10000, 20, k);
      wait_cyc(k + DEB);
      check("s4_pause_pre1", 32'(pause_state), 32'h0);
      wait_cyc(k + DEB + 1);
      check("s4_pause_on", 32'(pause_state), 32'h1);
      release_btn(5'b10000, k, 20);
      repeat (12) @(negedge clk);
      start(5'b10000, 20, k);
      wait_cyc(k + DEB);
      check("s4_pause_pre2", 32'(pause_state), 32'h1);
      wait_cyc(k + DEB + 1);
      check("s4_pause_off", 32'(pause_state), 32'h0);
      release_btn(5'b10000, k, 20);
      repeat (12) @(negedge clk);

      // Set pause, then async reset while left is repeating
      start(5'b10000, 8, k);
      release_btn(5'b10000, k, 8);
      repeat (12) @(negedge clk);
      k          = cyc + 1;
      btn_raw[0] = 1'b1;
      push(k + DEB + 1, 0);
      if (rep_en(0)) push(k + DEB + 1 + RDLY, 0);
      wait_cyc(k + DEB + 1 + RDLY + 2);
      #2;
      reset = 1'b0;
      sb.delete();
      exp_pause = 1'b0;
      #1;
      check("s5_rst_level", 32'(btn_level), 32'h0);
      check("s5_rst_pulse", 32'(btn_pulse), 32'h0);
      check("s5_rst_pause", 32'(pause_state), 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      start(5'b00001, 30, k);
      wait_cyc(k + DEB);
      check("s5_relevel_pre", 32'(btn_level[0]), 32'h0);
      wait_cyc(k + DEB + 1);
      check("s5_relevel_on", 32'(btn_level[0]), 32'h1);
      release_btn(5'b00001, k, 30);
      repeat (15) @(negedge clk);

      // Left and right pressed together
      start(5'b00011, 12, k);
      wait_cyc(k + DEB + 1);
      check("s6_both_level", 32'(btn_level[1:0]), 32'h3);
      release_btn(5'b00011, k, 12);
      repeat (15) @(negedge clk);

      mon_en = 1'b0;
      check("sb_drain", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
